// File: rtl/sr_flag_arbiter_pkg.sv
// Shared SR codes, op codes and the round-robin pick helper for the SR flag arbiter.
package sr_arb_pkg;

  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_CLR  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;

  localparam logic OP_CLR = 1'b0;
  localparam logic OP_SET = 1'b1;

  // Widest requester vector the helper handles (N_REQ <= 16).
  localparam int MAX_REQ = 16;

  // First set bit of eff at or after ptr, wrapping modulo n. Returns 0 when eff is empty.
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] eff,
                                         input logic [3:0]         ptr,
                                         input int                 n);
    logic [3:0] w;
    logic [3:0] j;
    logic       found;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = 4'((int'(ptr) + k) % n);
      if (!found && (k < n) && eff[j]) begin
        w     = j;
        found = 1'b1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/sr_flag_arbiter_cell.sv
// One SR flag cell: 10 sets, 01 clears, 00 and the forbidden 11 both hold.
module sr_flag_cell
  import sr_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sr,
  output logic       q
);

  // Flag storage with synchronous reset; 11 is treated as hold so a glitch cannot flip q.
  always_ff @(posedge clk) begin
    if (!rst_n) q <= 1'b0;
    else begin
      case (sr)
        SR_SET:  q <= 1'b1;
        SR_CLR:  q <= 1'b0;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters set/clear a bank of SR flag cells,
// one update per cycle, with a registered one-hot grant and an out-of-range error pulse.
module sr_flag_arbiter
  import sr_arb_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int N_FLAGS = 8,
  localparam int IDX_W   = $clog2(N_FLAGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       op,
  input  logic [N_REQ*IDX_W-1:0] idx,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_FLAGS-1:0]     flags,
  output logic                   err,
  output logic                   busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        eff;
  logic [PW-1:0]           ptr;
  logic [PW-1:0]           w;
  logic [IDX_W-1:0]        widx;
  logic                    wop;
  logic                    in_rng;
  logic [N_FLAGS-1:0][1:0] cell_sr;

  // A requester granted last edge is masked so a late-dropped req is not applied twice.
  assign eff    = req & ~gnt;
  assign busy   = |eff;
  assign w      = PW'(rr_pick(MAX_REQ'(eff), 4'(ptr), N_REQ));
  assign widx   = idx[int'(w)*IDX_W +: IDX_W];
  assign wop    = op[w];
  assign in_rng = (int'(widx) < N_FLAGS);

  // Per-cell SR decode: only the winning in-range cell gets SET/CLR, never 11.
  always_comb begin
    for (int j = 0; j < N_FLAGS; j++) begin
      cell_sr[j] = SR_HOLD;
      if (busy && in_rng && (int'(widx) == j))
        cell_sr[j] = (wop == OP_SET) ? SR_SET : SR_CLR;
    end
  end

  // Grant, error pulse and round-robin pointer; reset wins over a pending update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt <= '0;
      err <= 1'b0;
      ptr <= '0;
    end else if (busy) begin
      gnt <= N_REQ'(1) << w;
      err <= !in_rng;
      ptr <= PW'((int'(w) + 1) % N_REQ);
    end else begin
      gnt <= '0;
      err <= 1'b0;
    end
  end

  for (genvar g = 0; g < N_FLAGS; g++) begin : g_cell
    sr_flag_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .sr    (cell_sr[g]),
      .q     (flags[g])
    );
  end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Scoreboard bench: the driver predicts each edge's outcome from a behavioural model
// and queues it; the monitor pops one expectation per edge and compares.
module tb_sr_flag_arbiter;

  localparam int NR = 4;
  localparam int NF = 6;
  localparam int IW = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [NR-1:0]    op = '0;
  logic [NR*IW-1:0] idx = '0;
  logic [NR-1:0]    gnt;
  logic [NF-1:0]    flags;
  logic             err;
  logic             busy;

  sr_flag_arbiter #(.N_REQ(NR), .N_FLAGS(NF)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .idx(idx),
    .gnt(gnt), .flags(flags), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] gnt;
    logic          err;
    logic [NF-1:0] flags;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: value visible after the most recent edge.
  logic [NR-1:0] m_gnt = '0;
  logic          m_err = 1'b0;
  bit            m_flag[NF];
  int            m_ptr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the outcome of the coming edge.
  task automatic cyc(input logic r, input logic [NR-1:0] rq, input logic [NR-1:0] o,
                     input logic [NR*IW-1:0] ix);
    logic [NR-1:0] e;
    exp_t x;
    int w;
    @(negedge clk);
    rst_n = r; req = rq; op = o; idx = ix;
    if (!r) begin
      foreach (m_flag[i]) m_flag[i] = 1'b0;
      m_gnt = '0; m_err = 1'b0; m_ptr = 0;
    end else begin
      e = rq & ~m_gnt;
      w = -1;
      for (int k = 0; k < NR; k++)
        if (w < 0 && e[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
      if (w < 0) begin
        m_gnt = '0; m_err = 1'b0;
      end else begin
        int fi;
        fi = int'(ix[w*IW +: IW]);
        m_gnt = '0; m_gnt[w] = 1'b1;
        m_ptr = (w + 1) % NR;
        m_err = (fi >= NF);
        if (fi < NF) m_flag[fi] = o[w];
      end
    end
    x.gnt = m_gnt; x.err = m_err;
    for (int i = 0; i < NF; i++) x.flags[i] = m_flag[i];
    exp_q.push_back(x);
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  // Monitor: compare each edge's outcome, plus protocol and fairness properties.
  int wait_cnt[NR];
  initial begin
    exp_t e;
    foreach (wait_cnt[i]) wait_cnt[i] = 0;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt", 32'(gnt), 32'(e.gnt));
        chk("err", 32'(err), 32'(e.err));
        chk("flags", 32'(flags), 32'(e.flags));
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        for (int j = 0; j < NF; j++)
          if (dut.cell_sr[j] === 2'b11) chk("sr_not_11", 32'(dut.cell_sr[j]), 32'd0);
        for (int i = 0; i < NR; i++) begin
          if (!rst_n || !req[i]) wait_cnt[i] = 0;
          else if (gnt[i]) begin
            if (wait_cnt[i] > NR) chk("fairness_wait", 32'(wait_cnt[i]), 32'(NR));
            wait_cnt[i] = 0;
          end else begin
            wait_cnt[i]++;
            if (wait_cnt[i] == NR + 1) chk("fairness_wait", 32'(wait_cnt[i]), 32'(NR));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: run did not end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NR-1:0]    rq;
    logic [NR-1:0]    no;
    logic [NR*IW-1:0] nix;
    logic             r;
    logic [3:0]       gseq [4];
    gseq[0] = 4'b0001; gseq[1] = 4'b0010; gseq[2] = 4'b0100; gseq[3] = 4'b1000;

    // Reset held two cycles with every requester asking.
    cyc(1'b0, 4'b1111, 4'b1111, 12'h688);
    cyc(1'b0, 4'b1111, 4'b1111, 12'h688);
    settle();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);

    // Round-robin from ptr=0: each requester drops once its grant is seen.
    rq = 4'b1111;
    for (int k = 0; k < NR; k++) begin
      cyc(1'b1, rq, 4'b1111, 12'h688);
      settle();
      chk("rr_gnt", 32'(gnt), 32'(gseq[k]));
      rq = rq & ~gseq[k];
    end
    cyc(1'b1, 4'b0000, 4'b0000, 12'h688);
    settle();
    chk("rr_flags", 32'(flags), 32'h0F);

    // Single set then clear of flag 5 by requester 2, from clean flags.
    cyc(1'b0, 4'b0000, 4'b0000, 12'h000);
    cyc(1'b1, 4'b0100, 4'b0100, 12'h140);
    settle();
    chk("set_gnt", 32'(gnt), 32'h4);
    chk("set_flags", 32'(flags), 32'h20);
    cyc(1'b1, 4'b0100, 4'b0000, 12'h140);   // masked edge
    settle();
    chk("mask_gnt", 32'(gnt), 32'h0);
    cyc(1'b1, 4'b0100, 4'b0000, 12'h140);
    settle();
    chk("clr_gnt", 32'(gnt), 32'h4);
    chk("clr_flags", 32'(flags), 32'h00);

    // Wrap: ptr is now 3, so requester 3 beats requester 0.
    cyc(1'b1, 4'b1001, 4'b1001, 12'h000);
    settle();
    chk("wrap_gnt3", 32'(gnt), 32'h8);
    cyc(1'b1, 4'b0001, 4'b1001, 12'h000);
    settle();
    chk("wrap_gnt0", 32'(gnt), 32'h1);

    // Out of range index 7 on a 6-flag bank.
    cyc(1'b1, 4'b0010, 4'b0010, 12'h038);
    settle();
    chk("oor_gnt", 32'(gnt), 32'h2);
    chk("oor_err", 32'(err), 32'h1);
    chk("oor_flags", 32'(flags), 32'h01);
    cyc(1'b1, 4'b0000, 4'b0000, 12'h038);
    settle();
    chk("oor_err_pulse", 32'(err), 32'h0);

    // Reset on the edge that would grant requester 0 a set of flag 3.
    cyc(1'b0, 4'b0001, 4'b0001, 12'h00B);
    settle();
    chk("rstmid_flags", 32'(flags), 32'h0);
    chk("rstmid_gnt", 32'(gnt), 32'h0);
    cyc(1'b1, 4'b0011, 4'b0011, 12'h00B);
    settle();
    chk("rstmid_ptr0", 32'(gnt), 32'h1);
    chk("rstmid_set3", 32'(flags), 32'h08);
    cyc(1'b1, 4'b0000, 4'b0000, 12'h00B);

    // Random traffic: requesters hold until granted, then drop or re-request.
    rq = '0; no = '0; nix = '0;
    for (int c = 0; c < 2000; c++) begin
      r = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < NR; i++) begin
        if (m_gnt[i] || (!rq[i] && $urandom_range(0, 2) == 0)) begin
          rq[i] = m_gnt[i] ? 1'($urandom_range(0, 1)) : 1'b1;
          no[i] = 1'($urandom_range(0, 1));
          nix[i*IW +: IW] = 3'($urandom_range(0, 7));
        end
      end
      cyc(r, rq, no, nix);
    end
    cyc(1'b1, 4'b0000, 4'b0000, 12'h000);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) settle();
    if (exp_q.size() > 0) chk("drain_queue", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
